status_frame_tx: RTL and testbench
==================================

// Module: status_frame_tx
// PURPOSE
//  Transmit side of the motorboard UART link; the outbound peer of the 16-byte rx frame path.
//  Latches a status payload (encoder position, pwm, hall state) on a send pulse and serialises it.
//  Output is 8N1, LSB first, on TX, followed by a CRC-16/CCITT-FALSE trailer.
//  Frames the transmission with the active-low tx_transmission line.
// PARAMETERS
//  CLKS_PER_BIT   16   CLK cycles per UART bit (16 MHz / 1 Mbaud); must be >= 9
//  PAYLOAD_BYTES  14   payload bytes per frame; frame = PAYLOAD_BYTES+2 bytes
//  GUARD_BITS     1    bit periods tx_transmission is low before first start / after last stop
// PORTS
//  CLK              in   1                 system clock, 16 MHz
//  rst_n            in   1                 async active-low reset
//  send             in   1                 one-cycle request; sampled only when busy=0
//  payload          in   8*PAYLOAD_BYTES   byte k = payload[8k+7:8k]; latched on accepted send
//  TX               out  1                 UART serial out, idle high
//  tx_transmission  out  1                 active-low frame enable, high when idle
//  busy             out  1                 high from the cycle after accepted send until frame end
//  done             out  1                 one-cycle pulse when frame completes
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - TX=1, tx_transmission=1, busy=0, done=0; FSM=IDLE.
//   - Bit/byte counters=0, CRC=16'hFFFF.
//   - Mid-frame reset aborts immediately: no partial byte is completed.
//  States: IDLE, LEAD, START, DATA, STOP, TRAIL. All outputs are registered.
//  IDLE:
//   - On send=1, latch payload, set CRC=FFFF, byte_idx=0, go to LEAD.
//   - Next cycle: busy=1, tx_transmission=0.
//  LEAD:
//   - Lasts GUARD_BITS*CLKS_PER_BIT cycles with TX=1, then go to START.
//  START:
//   - TX=0 for CLKS_PER_BIT cycles.
//   - If byte_idx<PAYLOAD_BYTES, fold the current byte into the CRC during the first 8 cycles.
//     Bit-serial, MSB first, poly 0x1021, no reflection, no xorout.
//  DATA:
//   - 8 bits, LSB first, each CLKS_PER_BIT cycles, then go to STOP.
//  STOP:
//   - TX=1 for CLKS_PER_BIT cycles.
//   - Then byte_idx++; go to START if byte_idx<PAYLOAD_BYTES+2, else go to TRAIL.
//  Byte source:
//   - idx<PAYLOAD_BYTES: payload byte.
//   - idx=PAYLOAD_BYTES: CRC[7:0].
//   - idx=PAYLOAD_BYTES+1: CRC[15:8].
//   - So the receiver sees {crc_hi,crc_lo} in the top 16 bits of its container.
//   - CRC is frozen once byte PAYLOAD_BYTES starts.
//  TRAIL:
//   - GUARD_BITS*CLKS_PER_BIT cycles with TX=1, tx_transmission=0, then go to IDLE.
//   - In the IDLE-entry cycle: tx_transmission=1, busy=0, done=1 for exactly that cycle.
//  Timing:
//   - Frame length from accepted send to done = (2*GUARD_BITS + 10*(PAYLOAD_BYTES+2))*CLKS_PER_BIT + 1 cycles.
//   - Defaults: 2593.
//  Boundaries:
//   - send while busy=1 is ignored, not queued.
//   - send in the done cycle is accepted (busy=0).
//   - payload changes after acceptance have no effect on the frame in flight.
//   - Counters saturate nowhere; bit counter wraps 0..CLKS_PER_BIT-1 only.
// TESTING
//  1. Reset mid-DATA of byte 5 -> TX=1, tx_transmission=1, busy=0 asynchronously.
//     Next send produces a full, correct frame.
//  2. PAYLOAD_BYTES=9, payload="123456789" (byte0=0x31) -> CRC 0x29B1.
//     Trailing bytes on TX are 0xB1 then 0x29; 11 bytes total.
//  3. Defaults, payload bytes 0x00..0x0D -> UART monitor decodes 16 bytes 00..0D then a CRC matching the C model.
//     Every start-bit edge is 160 cycles apart; done arrives 2593 cycles after send.
//  4. send pulsed again at cycles 100 and 2000 of a frame -> ignored, exactly one frame.
//     send in the done cycle -> second frame starts; tx_transmission returns low the next cycle.
//  5. Change payload 1 cycle after send -> transmitted bytes equal the originally latched value.
//  6. tx_transmission is low exactly 16 cycles before the first start bit and 16 cycles after the last stop bit.

Source files
------------

// File: rtl/status_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : status_frame_tx_if
// Description : Request/status bundle between a frame producer and the
//               status_frame_tx UART serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
interface status_frame_tx_if #(
   parameter int PAYLOAD_BYTES = 14
);
   logic                         i_send;
   logic [8*PAYLOAD_BYTES-1:0]   i_payload;
   logic                         o_tx;
   logic                         o_tx_transmission;
   logic                         o_busy;
   logic                         o_done;

   // Producer side: issues requests and observes the link
   modport master (
      output i_send,
      output i_payload,
      input  o_tx,
      input  o_tx_transmission,
      input  o_busy,
      input  o_done
   );

   // Serialiser side
   modport slave (
      input  i_send,
      input  i_payload,
      output o_tx,
      output o_tx_transmission,
      output o_busy,
      output o_done
   );
endinterface
`default_nettype wire

// File: rtl/status_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : status_frame_tx
// Description : Latches a status payload on a send pulse and transmits it as
//               8N1 LSB-first UART bytes followed by a CRC-16/CCITT-FALSE
//               trailer (low byte first), framed by an active-low
//               tx_transmission line with guard periods either side.
// Revision    : 1.0 - initial release
// ============================================================================
module status_frame_tx #(
   parameter int CLKS_PER_BIT  = 16,
   parameter int PAYLOAD_BYTES = 14,
   parameter int GUARD_BITS    = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   status_frame_tx_if.slave   bus
);
   localparam int c_CW = $clog2(CLKS_PER_BIT);
   localparam int c_SW = $clog2(GUARD_BITS + 8);
   localparam int c_IW = $clog2(PAYLOAD_BYTES + 3);

   localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_SW-1:0] c_GUARD_LAST = c_SW'(GUARD_BITS - 1);
   localparam logic [c_SW-1:0] c_DATA_LAST  = c_SW'(7);
   localparam logic [c_IW-1:0] c_PAY_BYTES  = c_IW'(PAYLOAD_BYTES);
   localparam logic [c_IW-1:0] c_FRAME_LAST = c_IW'(PAYLOAD_BYTES + 1);
   localparam logic [15:0]     c_CRC_INIT   = 16'hFFFF;
   localparam logic [15:0]     c_CRC_POLY   = 16'h1021;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_TRAIL = 3'd5
   } state_t;

   state_t                     r_state;
   logic [c_CW-1:0]            r_bit_cnt;
   logic [c_SW-1:0]            r_sub_cnt;   // guard-bit or data-bit index
   logic [c_IW-1:0]            r_byte_idx;
   logic [15:0]                r_crc;
   logic [8*PAYLOAD_BYTES-1:0] r_payload;
   logic                       r_tx;
   logic                       r_txn;
   logic                       r_busy;
   logic                       r_done;

   state_t                     w_state_nxt;
   logic [c_CW-1:0]            w_bit_cnt_nxt;
   logic [c_SW-1:0]            w_sub_cnt_nxt;
   logic [c_IW-1:0]            w_byte_idx_nxt;
   logic [15:0]                w_crc_nxt;
   logic                       w_tx_nxt;
   logic                       w_txn_nxt;
   logic                       w_busy_nxt;
   logic                       w_done_nxt;
   logic                       w_load;

   logic                       w_bit_end;
   logic [c_CW-1:0]            w_bit_cnt_inc;
   logic [7:0]                 w_cur_byte;
   logic                       w_crc_bit;
   logic                       w_crc_fb;
   logic [15:0]                w_crc_fold;

   assign w_bit_end     = (r_bit_cnt == c_BIT_LAST);
   assign w_bit_cnt_inc = w_bit_end ? '0 : r_bit_cnt + c_CW'(1);

   // Byte currently on the wire: payload, then CRC low, then CRC high
   always_comb begin
      w_cur_byte = r_crc[15:8];
      if (r_byte_idx < c_PAY_BYTES) begin
         w_cur_byte = r_payload[{r_byte_idx, 3'b000} +: 8];
      end else if (r_byte_idx == c_PAY_BYTES) begin
         w_cur_byte = r_crc[7:0];
      end
   end

   // One MSB-first CRC step using the bit selected by the start-bit cycle count
   always_comb begin
      w_crc_bit  = w_cur_byte[3'd7 - r_bit_cnt[2:0]];
      w_crc_fb   = r_crc[15] ^ w_crc_bit;
      w_crc_fold = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? c_CRC_POLY : 16'h0000);
   end

   // Next-state and next-output logic; every output is registered from here
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_sub_cnt_nxt  = r_sub_cnt;
      w_byte_idx_nxt = r_byte_idx;
      w_crc_nxt      = r_crc;
      w_tx_nxt       = r_tx;
      w_txn_nxt      = r_txn;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_load         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_nxt   = 1'b1;
            w_txn_nxt  = 1'b1;
            w_busy_nxt = 1'b0;
            if (bus.i_send) begin
               w_load         = 1'b1;
               w_crc_nxt      = c_CRC_INIT;
               w_byte_idx_nxt = '0;
               w_bit_cnt_nxt  = '0;
               w_sub_cnt_nxt  = '0;
               w_txn_nxt      = 1'b0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_LEAD;
            end
         end

         S_LEAD: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            if (w_bit_end) begin
               if (r_sub_cnt == c_GUARD_LAST) begin
                  w_sub_cnt_nxt = '0;
                  w_tx_nxt      = 1'b0;
                  w_state_nxt   = S_START;
               end else begin
                  w_sub_cnt_nxt = r_sub_cnt + c_SW'(1);
               end
            end
         end

         S_START: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            // CRC trailer bytes are never folded, so the CRC is frozen from here on
            if ((r_bit_cnt < c_CW'(8)) && (r_byte_idx < c_PAY_BYTES)) begin
               w_crc_nxt = w_crc_fold;
            end
            if (w_bit_end) begin
               w_sub_cnt_nxt = '0;
               w_tx_nxt      = w_cur_byte[0];
               w_state_nxt   = S_DATA;
            end
         end

         S_DATA: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            if (w_bit_end) begin
               if (r_sub_cnt == c_DATA_LAST) begin
                  w_sub_cnt_nxt = '0;
                  w_tx_nxt      = 1'b1;
                  w_state_nxt   = S_STOP;
               end else begin
                  w_sub_cnt_nxt = r_sub_cnt + c_SW'(1);
                  w_tx_nxt      = w_cur_byte[r_sub_cnt[2:0] + 3'd1];
               end
            end
         end

         S_STOP: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            if (w_bit_end) begin
               w_byte_idx_nxt = r_byte_idx + c_IW'(1);
               if (r_byte_idx == c_FRAME_LAST) begin
                  w_sub_cnt_nxt = '0;
                  w_state_nxt   = S_TRAIL;
               end else begin
                  w_tx_nxt    = 1'b0;
                  w_state_nxt = S_START;
               end
            end
         end

         S_TRAIL: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            if (w_bit_end) begin
               if (r_sub_cnt == c_GUARD_LAST) begin
                  w_sub_cnt_nxt = '0;
                  w_txn_nxt     = 1'b1;
                  w_busy_nxt    = 1'b0;
                  w_done_nxt    = 1'b1;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_sub_cnt_nxt = r_sub_cnt + c_SW'(1);
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counters, CRC and registered outputs; reset aborts any frame at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_sub_cnt  <= '0;
         r_byte_idx <= '0;
         r_crc      <= c_CRC_INIT;
         r_payload  <= '0;
         r_tx       <= 1'b1;
         r_txn      <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_sub_cnt  <= w_sub_cnt_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_crc      <= w_crc_nxt;
         r_tx       <= w_tx_nxt;
         r_txn      <= w_txn_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         if (w_load) begin
            r_payload <= bus.i_payload;
         end
      end
   end

   assign bus.o_tx              = r_tx;
   assign bus.o_tx_transmission = r_txn;
   assign bus.o_busy            = r_busy;
   assign bus.o_done            = r_done;
endmodule
`default_nettype wire

// File: tb/tb_status_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_frame_tx
// Description : Scoreboard bench for status_frame_tx: random payloads, a
//               byte-wise CRC model, a UART decoding monitor with framing
//               timing checks, plus a 9-byte instance for the check vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_frame_tx;
   localparam int C  = 16;
   localparam int P  = 14;
   localparam int G  = 1;
   localparam int P9 = 9;
   localparam int FRAME_LAT = (2*G + 10*(P+2))*C + 1;

   typedef logic [7:0] bq_t[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   bq_t  exp_q;
   bq_t  got9;

   status_frame_tx_if #(.PAYLOAD_BYTES(P))  bus ();
   status_frame_tx_if #(.PAYLOAD_BYTES(P9)) bus9 ();

   status_frame_tx #(.CLKS_PER_BIT(C), .PAYLOAD_BYTES(P), .GUARD_BITS(G)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   status_frame_tx #(.CLKS_PER_BIT(C), .PAYLOAD_BYTES(P9), .GUARD_BITS(G)) u_dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus9)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used for timestamps
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte-at-a-time CRC-16/CCITT-FALSE
   function automatic logic [15:0] crc_model(input bq_t b);
      logic [15:0] crc;
      crc = 16'hFFFF;
      foreach (b[i]) begin
         crc = crc ^ {b[i], 8'h00};
         for (int j = 0; j < 8; j++) begin
            crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
         end
      end
      return crc;
   endfunction

   function automatic logic [8*P-1:0] rand_payload();
      logic [8*P-1:0] v;
      for (int k = 0; k < P; k++) v[8*k +: 8] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   task automatic push_expected(input logic [8*P-1:0] pay);
      bq_t         b;
      logic [15:0] crc;
      for (int k = 0; k < P; k++) b.push_back(pay[8*k +: 8]);
      crc = crc_model(b);
      foreach (b[i]) exp_q.push_back(b[i]);
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
   endtask

   // ---------------- UART monitor for the main instance ----------------
   bit         m_active   = 1'b0;
   int         m_cnt      = 0;
   int         m_nbytes   = 0;
   int         t_txn_fall = 0;
   int         t_last     = 0;
   logic       m_prev_tx  = 1'b1;
   logic       m_prev_txn = 1'b1;
   logic [7:0] m_byte     = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active   = 1'b0;
         m_nbytes   = 0;
         m_prev_tx  = 1'b1;
         m_prev_txn = 1'b1;
      end else begin
         if (m_prev_txn && !bus.o_tx_transmission) t_txn_fall = cyc;
         if (!m_prev_txn && bus.o_tx_transmission) begin
            check_int("trail_guard", cyc - t_last, 10*C + G*C);
            check_int("bytes_per_frame", m_nbytes, P + 2);
            m_nbytes = 0;
         end
         if (!m_active) begin
            if (m_prev_tx && !bus.o_tx) begin
               m_active = 1'b1;
               m_cnt    = 0;
               if (m_nbytes == 0) check_int("lead_guard", cyc - t_txn_fall, G*C);
               else               check_int("start_spacing", cyc - t_last, 10*C);
               t_last = cyc;
               m_nbytes++;
            end
         end else begin
            m_cnt++;
            if (m_cnt == C/2) begin
               check_int("start_bit", int'(bus.o_tx), 0);
            end else if (m_cnt >= C + C/2 && m_cnt <= 8*C + C/2 && (m_cnt % C) == C/2) begin
               m_byte[m_cnt/C - 1] = bus.o_tx;
            end else if (m_cnt == 9*C + C/2) begin
               check_int("stop_bit", int'(bus.o_tx), 1);
               if (exp_q.size() == 0) begin
                  check_int("unexpected_byte", int'(m_byte), -1);
               end else begin
                  check_int("tx_byte", int'(m_byte), int'(exp_q.pop_front()));
               end
               m_active = 1'b0;
            end
         end
         m_prev_tx  = bus.o_tx;
         m_prev_txn = bus.o_tx_transmission;
      end
   end

   // ---------------- UART monitor for the 9-byte instance ----------------
   bit         n_active  = 1'b0;
   int         n_cnt     = 0;
   logic       n_prev_tx = 1'b1;
   logic [7:0] n_byte    = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         n_active  = 1'b0;
         n_prev_tx = 1'b1;
      end else begin
         if (!n_active) begin
            if (n_prev_tx && !bus9.o_tx) begin
               n_active = 1'b1;
               n_cnt    = 0;
            end
         end else begin
            n_cnt++;
            if (n_cnt >= C + C/2 && n_cnt <= 8*C + C/2 && (n_cnt % C) == C/2) begin
               n_byte[n_cnt/C - 1] = bus9.o_tx;
            end else if (n_cnt == 9*C + C/2) begin
               got9.push_back(n_byte);
               n_active = 1'b0;
            end
         end
         n_prev_tx = bus9.o_tx;
      end
   end

   // ---------------- stimulus ----------------
   // Issue send with pay; the payload input is scrambled right after acceptance
   task automatic start_frame(input logic [8*P-1:0] pay);
      @(posedge clk); #1;
      bus.i_send    = 1'b1;
      bus.i_payload = pay;
      push_expected(pay);
      @(posedge clk); #1;
      bus.i_send    = 1'b0;
      bus.i_payload = rand_payload();
      check_int("busy_after_send", int'(bus.o_busy), 1);
      check_int("txn_after_send", int'(bus.o_tx_transmission), 0);
   endtask

   // Wait for done; optionally poke send while busy and chain a frame in the done cycle
   task automatic wait_done(input bit inject, input bit chain);
      int             n;
      bit             ok;
      logic [8*P-1:0] nxt;
      n  = 1;
      ok = 1'b0;
      while (n < 3*FRAME_LAT) begin
         @(posedge clk); #1;
         n++;
         bus.i_send = 1'b0;
         if (bus.o_done) begin
            ok = 1'b1;
            break;
         end
         if (inject && (n == 100 || n == 2000)) begin
            check_int("busy_mid_frame", int'(bus.o_busy), 1);
            bus.i_send    = 1'b1;
            bus.i_payload = rand_payload();
         end
      end
      check_int("done_seen", int'(ok), 1);
      check_int("done_latency", n, FRAME_LAT);
      check_int("busy_at_done", int'(bus.o_busy), 0);
      check_int("txn_at_done", int'(bus.o_tx_transmission), 1);
      check_int("queue_drained", exp_q.size(), 0);
      if (chain) begin
         nxt           = rand_payload();
         bus.i_send    = 1'b1;
         bus.i_payload = nxt;
         push_expected(nxt);
      end
      @(posedge clk); #1;
      bus.i_send = 1'b0;
      check_int("done_one_cycle", int'(bus.o_done), 0);
      if (chain) begin
         check_int("chain_txn_low", int'(bus.o_tx_transmission), 0);
         check_int("chain_busy", int'(bus.o_busy), 1);
      end
   endtask

   initial begin
      logic [8*P-1:0]  pay;
      logic [8*P9-1:0] pay9;
      int              n;

      bus.i_send     = 1'b0;
      bus.i_payload  = '0;
      bus9.i_send    = 1'b0;
      bus9.i_payload = '0;

      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_int("rst_tx", int'(bus.o_tx), 1);
      check_int("rst_txn", int'(bus.o_tx_transmission), 1);
      check_int("rst_busy", int'(bus.o_busy), 0);
      check_int("rst_done", int'(bus.o_done), 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Incrementing payload
      for (int k = 0; k < P; k++) pay[8*k +: 8] = 8'(k);
      start_frame(pay);
      wait_done(1'b0, 1'b0);

      // Sends while busy are dropped; send in the done cycle starts a new frame
      start_frame(rand_payload());
      wait_done(1'b1, 1'b1);
      wait_done(1'b0, 1'b0);

      // Random payloads
      for (int f = 0; f < 3; f++) begin
         start_frame(rand_payload());
         wait_done(1'b0, 1'b0);
      end

      // Asynchronous reset in the middle of byte 5 data bits
      start_frame(rand_payload());
      repeat (G*C + 5*10*C + 3*C) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_int("abort_tx", int'(bus.o_tx), 1);
      check_int("abort_txn", int'(bus.o_tx_transmission), 1);
      check_int("abort_busy", int'(bus.o_busy), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_int("abort_done", int'(bus.o_done), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      start_frame(rand_payload());
      wait_done(1'b0, 1'b0);

      // Nine-byte instance with the "123456789" check vector
      for (int k = 0; k < P9; k++) pay9[8*k +: 8] = 8'(8'h31 + k);
      got9.delete();
      @(posedge clk); #1;
      bus9.i_send    = 1'b1;
      bus9.i_payload = pay9;
      @(posedge clk); #1;
      bus9.i_send    = 1'b0;
      n = 0;
      while (!bus9.o_done && n < 3*FRAME_LAT) begin
         @(posedge clk); #1;
         n++;
      end
      check_int("crc9_done", int'(bus9.o_done), 1);
      check_int("crc9_bytes", got9.size(), P9 + 2);
      if (got9.size() == P9 + 2) begin
         for (int k = 0; k < P9; k++) check_int("crc9_payload", int'(got9[k]), 8'h31 + k);
         check_int("crc9_lo", int'(got9[P9]), 8'hB1);
         check_int("crc9_hi", int'(got9[P9+1]), 8'h29);
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
